// File: rtl/cmd_sched_arbiter.sv
// Round-robin arbiter sharing one command executor among N_REQ requesters.
// One command in flight; accept timeout in SEND and a guard delay after every command.
module cmd_sched_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CMD_W        = 3,
  parameter int TIMER_W      = 28,
  parameter int GUARD_CYCLES = 200000000,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CMD_W-1:0] req_cmd,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic [CMD_W-1:0]       command,
  output logic                   start,
  input  logic                   ready_command,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GUARD_INIT = TIMER_W'(GUARD_CYCLES);

  // Executor handshake: start rises with grant and stays high until the executor
  // pulls ready_command low (accept); the command is complete when ready_command
  // returns high. ready_command low on the first SEND cycle counts as accept.
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAITCOM = 2'd2, GUARD = 2'd3} state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]   owner, owner_d;
  logic [ACK_W-1:0]   ack_cnt, ack_cnt_d;
  logic [TIMER_W-1:0] guard_cnt, guard_cnt_d;
  logic [N_REQ-1:0]   grant_d, done_d;
  logic [CMD_W-1:0]   command_d;
  logic               start_d, err_d;

  logic [CMD_W-1:0]   cmd_arr [N_REQ];
  logic               any_req;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic [PTR_W-1:0]   rr_next;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) cmd_arr[i] = req_cmd[i*CMD_W +: CMD_W];
  end

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!any_req && req[cand_idx]) begin
        any_req = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign rr_next = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (en && any_req) state_d = SEND;
      SEND:    if (!ready_command) state_d = WAITCOM;
               else if (ack_cnt == ACK_LAST) state_d = GUARD;
      WAITCOM: if (ready_command) state_d = GUARD;
      GUARD:   if (guard_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner;
    command_d   = command;
    grant_d     = grant;
    start_d     = start;
    done_d      = '0;
    err_d       = 1'b0;
    rr_ptr_d    = rr_ptr;
    ack_cnt_d   = ack_cnt;
    guard_cnt_d = guard_cnt;
    unique case (state)
      IDLE: begin
        if (en && any_req) begin
          owner_d   = win_idx;
          command_d = cmd_arr[win_idx];
          grant_d   = N_REQ'(1) << win_idx;
          start_d   = 1'b1;
          ack_cnt_d = '0;
        end
      end
      SEND: begin
        if (!ready_command) begin
          start_d = 1'b0;
        end else if (ack_cnt == ACK_LAST) begin
          start_d     = 1'b0;
          grant_d     = '0;
          done_d      = N_REQ'(1) << owner;
          err_d       = 1'b1;
          rr_ptr_d    = rr_next;
          guard_cnt_d = GUARD_INIT;
        end else begin
          ack_cnt_d = ack_cnt + ACK_W'(1);
        end
      end
      WAITCOM: begin
        if (ready_command) begin
          grant_d     = '0;
          done_d      = N_REQ'(1) << owner;
          rr_ptr_d    = rr_next;
          guard_cnt_d = GUARD_INIT;
        end
      end
      GUARD: begin
        if (guard_cnt != '0) guard_cnt_d = guard_cnt - TIMER_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= '0;
      command   <= '0;
      grant     <= '0;
      start     <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      rr_ptr    <= '0;
      ack_cnt   <= '0;
      guard_cnt <= '0;
    end else begin
      owner     <= owner_d;
      command   <= command_d;
      grant     <= grant_d;
      start     <= start_d;
      done      <= done_d;
      err       <= err_d;
      rr_ptr    <= rr_ptr_d;
      ack_cnt   <= ack_cnt_d;
      guard_cnt <= guard_cnt_d;
    end
  end

endmodule

// File: tb/tb_cmd_sched_arbiter.sv
// Directed bench for cmd_sched_arbiter: instance a (guard 4, timeout 8) and
// instance b (no guard) for the round-robin sequence.
module tb_cmd_sched_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;

  logic [3:0]  req_a, grant_a, done_a;
  logic [11:0] cmd_a;
  logic [2:0]  command_a;
  logic        err_a, start_a, rdy_a, busy_a;

  logic [3:0]  req_b, grant_b, done_b;
  logic [11:0] cmd_b;
  logic [2:0]  command_b;
  logic        err_b, start_b, rdy_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cmd_sched_arbiter #(.N_REQ(4), .CMD_W(3), .TIMER_W(28), .GUARD_CYCLES(4), .ACK_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req(req_a), .req_cmd(cmd_a), .grant(grant_a),
    .done(done_a), .err(err_a), .command(command_a), .start(start_a),
    .ready_command(rdy_a), .busy(busy_a)
  );

  cmd_sched_arbiter #(.N_REQ(4), .CMD_W(3), .TIMER_W(28), .GUARD_CYCLES(0), .ACK_TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .req(req_b), .req_cmd(cmd_b), .grant(grant_b),
    .done(done_b), .err(err_b), .command(command_b), .start(start_b),
    .ready_command(rdy_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1;
    req_a = '0; cmd_a = '0; rdy_a = 1'b1;
    req_b = '0; cmd_b = '0; rdy_b = 1'b1;
    tick(); tick();
    check("rst_grant", 32'(grant_a), 0);
    check("rst_start", 32'(start_a), 0);
    check("rst_done_err", 32'({done_a, err_a}), 0);
    check("rst_busy", 32'(busy_a), 0);
    rst = 1'b1;
    tick();

    // Round-robin with all requesters held, no guard
    req_b = 4'b1111;
    cmd_b = {3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rr_grant", 32'(grant_b), 32'(4'b0001 << (i % 4)));
      check("rr_command", 32'(command_b), 32'(i % 4));
      check("rr_start", 32'(start_b), 1);
      rdy_b = 1'b0;
      tick();
      check("rr_start_fall", 32'(start_b), 0);
      rdy_b = 1'b1;
      tick();
      check("rr_done", 32'(done_b), 32'(4'b0001 << (i % 4)));
      check("rr_grant_clear", 32'(grant_b), 0);
      if (i == 4) req_b = '0;
      tick();
      check("rr_gap", 32'({grant_b, done_b}), 0);
      tick();
    end
    check("rr_idle_end", 32'(grant_b), 0);

    // Single requester, executor accepts after 2 cycles and completes 3 later
    req_a = 4'b0100;
    cmd_a = 12'd5 << 6;
    tick();
    check("t1_grant", 32'(grant_a), 32'(4'b0100));
    check("t1_start", 32'(start_a), 1);
    check("t1_command", 32'(command_a), 5);
    check("t1_busy", 32'(busy_a), 1);
    tick(); tick();
    rdy_a = 1'b0;
    tick();
    check("t1_start_fall", 32'(start_a), 0);
    check("t1_grant_held", 32'(grant_a), 32'(4'b0100));
    tick(); tick();
    rdy_a = 1'b1;
    req_a = '0;
    tick();
    check("t1_done", 32'(done_a), 32'(4'b0100));
    check("t1_err", 32'(err_a), 0);
    check("t1_grant_clear", 32'(grant_a), 0);
    tick();
    check("t1_done_pulse", 32'(done_a), 0);
    tick(); tick(); tick();
    check("t1_busy_guard", 32'(busy_a), 1);
    tick(); tick();
    check("t1_busy_low", 32'(busy_a), 0);

    // Request withdrawn and command changed right after grant
    req_a = 4'b1000;
    cmd_a = 12'd6 << 9;
    tick();
    check("t4_grant", 32'(grant_a), 32'(4'b1000));
    check("t4_command", 32'(command_a), 6);
    req_a = '0;
    cmd_a = 12'hfff;
    rdy_a = 1'b0;
    tick(); tick();
    check("t4_command_held", 32'(command_a), 6);
    rdy_a = 1'b1;
    tick();
    check("t4_done", 32'(done_a), 32'(4'b1000));
    check("t4_command_after", 32'(command_a), 6);
    repeat (6) tick();
    check("t4_idle", 32'({busy_a, grant_a}), 0);
    check("t4_rr_ptr", 32'(dut_a.rr_ptr), 0);

    // Accept timeout with ready_command stuck high
    req_a = 4'b0010;
    cmd_a = '0;
    tick();
    check("t3_grant", 32'(grant_a), 32'(4'b0010));
    check("t3_start_0", 32'(start_a), 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("t3_start_hold", 32'(start_a), 1);
    end
    tick();
    check("t3_start_drop", 32'(start_a), 0);
    check("t3_done", 32'(done_a), 32'(4'b0010));
    check("t3_err", 32'(err_a), 1);
    check("t3_grant_clear", 32'(grant_a), 0);
    check("t3_rr_ptr", 32'(dut_a.rr_ptr), 2);
    req_a = '0;
    tick();
    check("t3_pulse_clear", 32'({done_a, err_a}), 0);
    repeat (6) tick();

    // en dropped during WAITCOM
    req_a = 4'b0011;
    cmd_a = {3'd0, 3'd0, 3'd2, 3'd1};
    tick();
    check("t5_grant0", 32'(grant_a), 32'(4'b0001));
    check("t5_command0", 32'(command_a), 1);
    rdy_a = 1'b0;
    tick();
    en = 1'b0;
    tick();
    rdy_a = 1'b1;
    tick();
    check("t5_done", 32'(done_a), 32'(4'b0001));
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_no_grant", 32'(grant_a), 0);
    end
    check("t5_rr_ptr", 32'(dut_a.rr_ptr), 1);
    en = 1'b1;
    tick();
    check("t5_grant1", 32'(grant_a), 32'(4'b0010));
    check("t5_command1", 32'(command_a), 2);

    // Asynchronous reset during WAITCOM
    rdy_a = 1'b0;
    tick();
    check("t6_waitcom", 32'(dut_a.state), 2);
    rdy_a = 1'b1;
    tick();
    check("t6_done1", 32'(done_a), 32'(4'b0010));
    repeat (6) tick();
    check("t6_grant_again", 32'(grant_a), 32'(4'b0001));
    check("t6_rr_ptr_pre", 32'(dut_a.rr_ptr), 2);
    rdy_a = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("t6_async_outs", 32'({grant_a, done_a, err_a, start_a, command_a}), 0);
    check("t6_async_busy", 32'(busy_a), 0);
    check("t6_async_state", 32'(dut_a.state), 0);
    check("t6_async_rr_ptr", 32'(dut_a.rr_ptr), 0);
    req_a = 4'b0001;
    cmd_a = 12'd4;
    rdy_a = 1'b1;
    #1 rst = 1'b1;
    tick();
    check("t6_regrant", 32'(grant_a), 32'(4'b0001));
    check("t6_restart", 32'(start_a), 1);
    check("t6_recommand", 32'(command_a), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmd_sched_arbiter.md
Name: cmd_sched_arbiter

Overview:
- Shares the single command executor (start/ready_command handshake, 3-bit command) between N_REQ requesters.
- Round-robin arbitration, one command in flight at a time.
- Per-command accept timeout and a programmable guard delay between commands.
- Sits between requester FSMs and the executor, replacing the fixed command sequencer when several sources must issue commands.

Parameters:
N_REQ, 4, number of requesters (2..8)
CMD_W, 3, command width
TIMER_W, 28, guard counter width
GUARD_CYCLES, 200000000, idle cycles after each command before next grant (0 = no guard)
ACK_TIMEOUT, 1024, max cycles in SEND waiting for executor to drop ready_command

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  high: new grants allowed; low: finish current command, then hold in IDLE
req  in  N_REQ  level request per requester
req_cmd  in  N_REQ*CMD_W  command per requester, slice i = bits [i*CMD_W +: CMD_W]
grant  out  N_REQ  one-hot owner of executor, high from grant edge until done/err edge
done  out  N_REQ  one-cycle pulse to the owner on completion or abort
err  out  1  one-cycle pulse coincident with done when aborted by ACK_TIMEOUT
command  out  CMD_W  command to executor, latched at grant
start  out  1  start request to executor
ready_command  in  1  executor ready: high = idle/finished, low = busy
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=0): state IDLE, start=0, command=0, grant=0, done=0, err=0, rr_ptr=0, counters=0. Applies immediately mid-command; the executor is not notified.
- rr_ptr: highest-priority index. Search order is rr_ptr, rr_ptr+1, … mod N_REQ.
- IDLE:
  - If en=1 and |req: at that edge latch winner W, command<=req_cmd[W], grant<=onehot(W), start<=1, ack_cnt<=0, go SEND.
  - Latency is 1 clock from req seen to grant/start.
- SEND: start held 1.
  - If ready_command=0: start<=0, go WAITCOM.
  - Else if ack_cnt==ACK_TIMEOUT-1: abort. start<=0, grant<=0, done[W]<=1, err<=1, rr_ptr<=W+1 mod N_REQ, go GUARD with guard_cnt<=GUARD_CYCLES.
  - Else ack_cnt++.
- WAITCOM: wait for ready_command=1. On that edge: grant<=0, done[W]<=1, rr_ptr<=W+1 mod N_REQ, guard_cnt<=GUARD_CYCLES, go GUARD. No timeout in WAITCOM.
- GUARD:
  - If guard_cnt==0: go IDLE.
  - Else guard_cnt--.
  - With GUARD_CYCLES=G, the earliest next grant edge is G+2 cycles after the done edge.
- done and err are single-cycle pulses, cleared the following cycle.
- Requests:
  - req_cmd only needs to be valid on the grant edge. Later changes do not affect command.
  - req withdrawn after grant is ignored; the command completes and done still pulses.
  - A requester that keeps req high after done is re-eligible, but at lowest priority.
- en=0 mid-command: no effect until IDLE is reached.
- ready_command already low while in IDLE: no effect. In SEND it is treated as accept on the first cycle.
- Counter widths: guard_cnt is TIMER_W bits. ack_cnt is clog2(ACK_TIMEOUT)+1 bits. Wrap-around is never reached.
- grant is never multi-hot. done is only ever asserted for the current W.

Test Plan:
1. Single requester: GUARD_CYCLES=4, req[2]=1, req_cmd[2]=3'd5; executor drops ready 2 cycles after start, raises 3 cycles later. Required: grant=4'b0100 and start=1 and command=5 one cycle after req; start falls on the accept edge; done[2] pulse on the ready-rise edge; busy low 6 cycles after done.
2. Round-robin: req=4'b1111 held, commands 0..3, GUARD_CYCLES=0. Required: grant order 0,1,2,3,0; each done precedes the next grant by 2 cycles.
3. Accept timeout: ACK_TIMEOUT=8, ready_command stuck 1, req[1]=1. Required: start high exactly 8 cycles, then done[1]=1 and err=1 for 1 cycle, grant=0, rr_ptr=2.
4. Requester drops req and changes req_cmd right after grant. Required: command stays at the latched value and done still pulses for that requester.
5. en=0 asserted during WAITCOM. Required: current command completes with done; no new grant while en=0 despite req=4'b0011; the grant to index rr_ptr follows one cycle after en=1.
6. rst pulsed low during WAITCOM. Required: all outputs 0 asynchronously, state IDLE, rr_ptr=0; after release, a pending req[0] is granted on the next edge.
